level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
- Top-level game sequencer above the per-pixel game FSM, which emits one-cycle win/lose pulses.
- Tracks lives and level, freezes play during death and level-up pauses, and pulses a frog re-spawn.
- Drives the scroll speed of logs and waterfall per level.
- Counts time in VGA frames using the startOfFrame strobe.

Parameters:
- LIVES_INIT, 3: lives loaded at game start (1..7).
- MAX_LEVEL, 7: last level; winning it ends the game (1..15).
- PAUSE_FRAMES, 60: frames frozen after a death or a level-up (1..255).
- BASE_SPEED, 16: object speed at level 1.
- SPEED_STEP, 8: speed increment per level.
- TIME_FRAMES, 1800: per-level time budget in frames (used only with the optional feature).

Ports:
- clk  in  1  system clock
- resetN  in  1  async active-low reset
- startOfFrame  in  1  one-cycle pulse per VGA frame
- start_key  in  1  raw level from the keypad (synchronised upstream)
- win  in  1  one-cycle pulse: frog reached end bank
- lose  in  1  one-cycle pulse: frog hit log, waterfall or other hazard
- level  out  4  current level, 1..MAX_LEVEL
- lives  out  3  remaining lives
- speed  out  8  object speed for the current level
- freeze  out  1  1 = movers hold position and ignore keys
- frog_reset  out  1  one-cycle pulse: re-spawn frog at the start bank
- game_over  out  1  high in GAME_OVER
- victory  out  1  high in VICTORY

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetN). All outputs registered.
- Reset values: state=IDLE, level=1, lives=LIVES_INIT, speed=BASE_SPEED, freeze=1, frog_reset=0, game_over=0, victory=0, frame counter=0.
- start_key: rising edge detected internally with one flop. Acts only in IDLE, GAME_OVER and VICTORY; ignored elsewhere.
- IDLE: freeze=1.
  - Start edge -> LOAD, with level=1 and lives=LIVES_INIT.
- LOAD: lasts exactly one cycle.
  - frog_reset=1 in the cycle after entry (registered); frame counter cleared.
  - Next state is PLAY.
- PLAY: freeze=0.
  - lose, lives>1: lives-=1 -> DYING.
  - lose, lives==1: lives=0 -> GAME_OVER.
  - win, level<MAX_LEVEL: level+=1 -> LEVEL_UP.
  - win, level==MAX_LEVEL: -> VICTORY; level unchanged.
  - win and lose in the same cycle: lose takes priority and win is discarded.
- DYING and LEVEL_UP: freeze=1.
  - Frame counter increments on each startOfFrame.
  - When it reaches PAUSE_FRAMES -> LOAD.
  - win/lose ignored.
- GAME_OVER: game_over=1, freeze=1.
- VICTORY: victory=1, freeze=1.
- GAME_OVER or VICTORY, start edge: -> LOAD, with level=1 and lives=LIVES_INIT.
- win/lose outside PLAY: ignored; no counter changes.
- Speed:
  - speed = BASE_SPEED + (level-1)*SPEED_STEP.
  - Computed at 9 bits, saturated to 255.
  - Updated the cycle after level changes.
- Frame counter: 8 bits; never wraps in use because it clears on LOAD.
- Reset mid-pause or mid-play: immediate return to IDLE with reset values; a pending frog_reset is dropped.
- A startOfFrame in the same cycle as the LOAD->PLAY transition is not counted.

Optional Feature:
- Macro: LEVEL_TIMER_EN.
- Defined:
  - Adds output time_left [10:0], loaded with TIME_FRAMES in LOAD.
  - Decrements on startOfFrame while in PLAY; holds while frozen.
  - At 0 in PLAY, behaves exactly as a lose pulse (same priority and lives handling).
  - win and timeout in the same cycle: timeout wins.
- Undefined: no port, no counter; a level has no time limit.

Decomposition:
- Package game_pkg holds:
  - state enum {IDLE, LOAD, PLAY, DYING, LEVEL_UP, GAME_OVER, VICTORY};
  - LEVEL_W=4, LIVES_W=3, SPEED_W=8.
- Sub-module frame_counter:
  - ports: clk, resetN, clear, enable, startOfFrame, terminal count;
  - outputs a done flag;
  - reused for pause timing and for the optional level timer.

Test Plan:
- Reset, then start_key edge -> frog_reset pulses once; freeze drops to 0 two cycles after the edge; level=1, lives=3, speed=16.
- In PLAY, lose pulse -> lives=2, freeze=1; after exactly 60 startOfFrame pulses -> frog_reset pulse, then freeze=0.
- Three lose pulses (each after its pause) -> lives=0, game_over=1. A further lose changes nothing; a start edge restores lives=3, level=1.
- Win pulses on levels 1..6 -> level reaches 7, speed=64. Win on level 7 -> victory=1 and level stays 7.
- win and lose asserted in the same cycle at lives=3, level=2 -> lives=2, level=2, state DYING.
- LEVEL_TIMER_EN defined, TIME_FRAMES=5 -> after 5 frames in PLAY: lives decrement, time_left=0, DYING entered. Frames during the freeze do not decrement time_left.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the level sequencer slice.
package game_pkg;

  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 3;
  localparam int SPEED_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    DYING,
    LEVEL_UP,
    GAME_OVER,
    VICTORY
  } state_t;

endpackage

// File: rtl/frame_counter.sv
// Counts VGA frame strobes up to a terminal count and raises done there.
// Used for the death/level-up pause and for the optional per-level timer.
module frame_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         clear,
  input  logic         enable,
  input  logic         startOfFrame,
  input  logic [W-1:0] terminal,
  output logic         done
);

  logic [W-1:0] count_reg;

  assign done = (count_reg == terminal);

  // Count enabled frames, saturating at terminal; clear wins over a same-cycle strobe
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && startOfFrame && !done) begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game-level sequencer: lives, level, pauses, frog re-spawn and scroll speed.
// Optional per-level time budget is compiled in with `define LEVEL_TIMER_EN.
module level_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int MAX_LEVEL    = 7,
  parameter int PAUSE_FRAMES = 60,
  parameter int BASE_SPEED   = 16,
  parameter int SPEED_STEP   = 8,
  parameter int TIME_FRAMES  = 1800
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               start_key,
  input  logic               win,
  input  logic               lose,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic [SPEED_W-1:0] speed,
  output logic               freeze,
  output logic               frog_reset,
  output logic               game_over,
  output logic               victory
`ifdef LEVEL_TIMER_EN
  ,
  output logic [10:0]        time_left
`endif
);

  // Reject parameter values the counters cannot represent
  if (LIVES_INIT < 1 || LIVES_INIT > 7) begin : g_bad_lives
    $error("LIVES_INIT must be 1..7");
  end
  if (MAX_LEVEL < 1 || MAX_LEVEL > 15) begin : g_bad_level
    $error("MAX_LEVEL must be 1..15");
  end
  if (PAUSE_FRAMES < 1 || PAUSE_FRAMES > 255) begin : g_bad_pause
    $error("PAUSE_FRAMES must be 1..255");
  end
  if (TIME_FRAMES < 1 || TIME_FRAMES > 2047) begin : g_bad_time
    $error("TIME_FRAMES must be 1..2047");
  end

  state_t             state_reg, state_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic [LIVES_W-1:0] lives_reg, lives_next;
  logic [SPEED_W-1:0] speed_reg;
  logic               freeze_reg, frog_reset_reg, game_over_reg, victory_reg;
  logic               start_d_reg;
  logic               start_edge;
  logic               pause_done;
  logic               lose_event;
  logic [8:0]         speed_wide;

  assign start_edge = start_key & ~start_d_reg;

  frame_counter #(.W(8)) u_pause_counter (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (state_reg == LOAD),
    .enable      ((state_reg == DYING) || (state_reg == LEVEL_UP)),
    .startOfFrame(startOfFrame),
    .terminal    (8'(PAUSE_FRAMES)),
    .done        (pause_done)
  );

`ifdef LEVEL_TIMER_EN
  logic        timer_done;
  logic [10:0] time_left_reg;

  frame_counter #(.W(11)) u_level_timer (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (state_reg == LOAD),
    .enable      (state_reg == PLAY),
    .startOfFrame(startOfFrame),
    .terminal    (11'(TIME_FRAMES)),
    .done        (timer_done)
  );

  // Visible countdown that tracks the level timer: reload on LOAD, tick down only in PLAY
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      time_left_reg <= 11'(TIME_FRAMES);
    end else if (state_reg == LOAD) begin
      time_left_reg <= 11'(TIME_FRAMES);
    end else if (state_reg == PLAY && startOfFrame && time_left_reg != 11'd0) begin
      time_left_reg <= time_left_reg - 11'd1;
    end
  end

  assign time_left  = time_left_reg;
  assign lose_event = lose | timer_done;
`else
  assign lose_event = lose;
`endif

  // Level 1 runs at BASE_SPEED; each level adds SPEED_STEP, clipped at full scale
  assign speed_wide = 9'(BASE_SPEED) + 9'(SPEED_STEP) * 9'(level_reg - LEVEL_W'(1));

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus level/lives updates; a loss always outranks a win
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    lives_next = lives_reg;
    case (state_reg)
      IDLE, GAME_OVER, VICTORY: begin
        if (start_edge) begin
          state_next = LOAD;
          level_next = LEVEL_W'(1);
          lives_next = LIVES_W'(LIVES_INIT);
        end
      end
      LOAD: state_next = PLAY;
      PLAY: begin
        if (lose_event) begin
          if (lives_reg > LIVES_W'(1)) begin
            lives_next = lives_reg - LIVES_W'(1);
            state_next = DYING;
          end else begin
            lives_next = '0;
            state_next = GAME_OVER;
          end
        end else if (win) begin
          if (level_reg < LEVEL_W'(MAX_LEVEL)) begin
            level_next = level_reg + LEVEL_W'(1);
            state_next = LEVEL_UP;
          end else begin
            state_next = VICTORY;
          end
        end
      end
      DYING, LEVEL_UP: begin
        if (pause_done) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered datapath and outputs; flags follow the state being entered
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      level_reg      <= LEVEL_W'(1);
      lives_reg      <= LIVES_W'(LIVES_INIT);
      speed_reg      <= SPEED_W'(BASE_SPEED);
      freeze_reg     <= 1'b1;
      frog_reset_reg <= 1'b0;
      game_over_reg  <= 1'b0;
      victory_reg    <= 1'b0;
      start_d_reg    <= 1'b0;
    end else begin
      level_reg      <= level_next;
      lives_reg      <= lives_next;
      speed_reg      <= speed_wide[8] ? {SPEED_W{1'b1}} : speed_wide[SPEED_W-1:0];
      freeze_reg     <= (state_next != PLAY);
      frog_reset_reg <= (state_reg == LOAD);
      game_over_reg  <= (state_next == GAME_OVER);
      victory_reg    <= (state_next == VICTORY);
      start_d_reg    <= start_key;
    end
  end

  assign level      = level_reg;
  assign lives      = lives_reg;
  assign speed      = speed_reg;
  assign freeze     = freeze_reg;
  assign frog_reset = frog_reset_reg;
  assign game_over  = game_over_reg;
  assign victory    = victory_reg;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with a scoreboard of expected output snapshots.
// Build with +define+LEVEL_TIMER_EN to exercise the level timer (TIME_FRAMES=5).
module tb_level_sequencer;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        start_key = 1'b0;
  logic        win = 1'b0;
  logic        lose = 1'b0;
  logic [3:0]  level;
  logic [2:0]  lives;
  logic [7:0]  speed;
  logic        freeze, frog_reset, game_over, victory;
`ifdef LEVEL_TIMER_EN
  logic [10:0] time_left;
`endif

  always #5 clk = ~clk;

  level_sequencer #(
    .LIVES_INIT  (3),
    .MAX_LEVEL   (7),
    .PAUSE_FRAMES(60),
    .BASE_SPEED  (16),
    .SPEED_STEP  (8),
`ifdef LEVEL_TIMER_EN
    .TIME_FRAMES (5)
`else
    .TIME_FRAMES (1800)
`endif
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .start_key   (start_key),
    .win         (win),
    .lose        (lose),
    .level       (level),
    .lives       (lives),
    .speed       (speed),
    .freeze      (freeze),
    .frog_reset  (frog_reset),
    .game_over   (game_over),
    .victory     (victory)
`ifdef LEVEL_TIMER_EN
    ,
    .time_left   (time_left)
`endif
  );

  int n_asserts = 0;
  int n_fail = 0;

  typedef struct {
    string tag;
    int    lvl;
    int    liv;
    int    spd;
    int    frz;
    int    fr;
    int    go;
    int    vic;
    int    tl;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input int lvl, input int liv, input int spd,
                      input int frz, input int fr, input int go, input int vic, input int tl);
    exp_t e;
    e.tag = tag; e.lvl = lvl; e.liv = liv; e.spd = spd;
    e.frz = frz; e.fr = fr; e.go = go; e.vic = vic; e.tl = tl;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    e = sb.pop_front();
    $display("[%0t] %s: level=%0d lives=%0d speed=%0d freeze=%0b frog_reset=%0b game_over=%0b victory=%0b",
             $time, e.tag, level, lives, speed, freeze, frog_reset, game_over, victory);
    chk({e.tag, ".level"},      32'(level),      e.lvl);
    chk({e.tag, ".lives"},      32'(lives),      e.liv);
    chk({e.tag, ".speed"},      32'(speed),      e.spd);
    chk({e.tag, ".freeze"},     32'(freeze),     e.frz);
    chk({e.tag, ".frog_reset"}, 32'(frog_reset), e.fr);
    chk({e.tag, ".game_over"},  32'(game_over),  e.go);
    chk({e.tag, ".victory"},    32'(victory),    e.vic);
`ifdef LEVEL_TIMER_EN
    if (e.tl >= 0) chk({e.tag, ".time_left"}, 32'(time_left), e.tl);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n frame strobes, each followed by two quiet cycles
  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic pulse(input logic w, input logic l);
    win = w;
    lose = l;
    tick();
    win = 1'b0;
    lose = 1'b0;
  endtask

  task automatic press_start();
    start_key = 1'b0;
    tick();
    start_key = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    push("reset", 1, 3, 16, 1, 0, 0, 0, -1);
    check_next();
    resetN = 1'b1;
    tick();
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    push("idle_ignores_win_lose", 1, 3, 16, 1, 0, 0, 0, -1);
    check_next();

    // Start: LOAD, then PLAY with one frog_reset pulse
    push("load", 1, 3, 16, 1, 0, 0, 0, -1);
    press_start();
    check_next();
    push("play_entry", 1, 3, 16, 0, 1, 0, 0, -1);
    tick();
    check_next();
    push("play", 1, 3, 16, 0, 0, 0, 0, -1);
    tick();
    check_next();
    push("start_in_play", 1, 3, 16, 0, 0, 0, 0, -1);
    press_start();
    check_next();

    // First death and a full pause; win during the pause is ignored
    push("lose1", 1, 2, 16, 1, 0, 0, 0, -1);
    pulse(1'b0, 1'b1);
    check_next();
    pulse(1'b1, 1'b0);
    push("pause59", 1, 2, 16, 1, 0, 0, 0, -1);
    frames(59);
    check_next();
    push("respawn1", 1, 2, 16, 0, 1, 0, 0, -1);
    frames(1);
    check_next();
    tick();

    push("lose2", 1, 1, 16, 1, 0, 0, 0, -1);
    pulse(1'b0, 1'b1);
    check_next();
    push("respawn2", 1, 1, 16, 0, 1, 0, 0, -1);
    frames(60);
    check_next();
    tick();

    // Last life lost, then nothing moves until start
    push("game_over", 1, 0, 16, 1, 0, 1, 0, -1);
    pulse(1'b0, 1'b1);
    check_next();
    push("game_over_hold", 1, 0, 16, 1, 0, 1, 0, -1);
    pulse(1'b0, 1'b1);
    frames(70);
    check_next();
    push("restart_load", 1, 3, 16, 1, 0, 0, 0, -1);
    press_start();
    check_next();
    push("restart_play", 1, 3, 16, 0, 1, 0, 0, -1);
    tick();
    check_next();
    tick();

    // Climb to the last level; speed follows one cycle after the level
    for (int lv = 1; lv <= 6; lv++) begin
      push($sformatf("lvl%0d_up", lv + 1), lv + 1, 3, 16 + (lv - 1) * 8, 1, 0, 0, 0, -1);
      pulse(1'b1, 1'b0);
      check_next();
      push($sformatf("lvl%0d_speed", lv + 1), lv + 1, 3, 16 + lv * 8, 1, 0, 0, 0, -1);
      tick();
      check_next();
      push($sformatf("lvl%0d_play", lv + 1), lv + 1, 3, 16 + lv * 8, 0, 1, 0, 0, -1);
      frames(60);
      check_next();
      tick();
    end

    push("victory", 7, 3, 64, 1, 0, 0, 1, -1);
    pulse(1'b1, 1'b0);
    check_next();
    push("victory_hold", 7, 3, 64, 1, 0, 0, 1, -1);
    pulse(1'b0, 1'b1);
    tick();
    check_next();
    push("victory_restart", 1, 3, 64, 1, 0, 0, 0, -1);
    press_start();
    check_next();
    push("victory_replay", 1, 3, 16, 0, 1, 0, 0, -1);
    tick();
    check_next();
    tick();

    // Level 2, then simultaneous win and lose: loss wins
    push("lvl2_up_again", 2, 3, 16, 1, 0, 0, 0, -1);
    pulse(1'b1, 1'b0);
    check_next();
    push("lvl2_play_again", 2, 3, 24, 0, 1, 0, 0, -1);
    frames(60);
    check_next();
    tick();
    push("win_and_lose", 2, 2, 24, 1, 0, 0, 0, -1);
    pulse(1'b1, 1'b1);
    check_next();
    push("mid_pause", 2, 2, 24, 1, 0, 0, 0, -1);
    frames(30);
    check_next();

    // Asynchronous reset in the middle of a pause
    push("async_reset", 1, 3, 16, 1, 0, 0, 0, -1);
    resetN = 1'b0;
    #2;
    check_next();
    start_key = 1'b0;
    tick();
    resetN = 1'b1;
    push("post_reset_idle", 1, 3, 16, 1, 0, 0, 0, -1);
    tick();
    tick();
    check_next();

    // Reset while in LOAD drops the pending frog_reset
    press_start();
    resetN = 1'b0;
    push("reset_in_load", 1, 3, 16, 1, 0, 0, 0, -1);
    tick();
    check_next();
    start_key = 1'b0;
    resetN = 1'b1;
    tick();
    tick();

`ifdef LEVEL_TIMER_EN
    // Level timer: counts only in PLAY, expiry behaves as a loss
    push("timer_play", 1, 3, 16, 0, 1, 0, 0, 5);
    press_start();
    tick();
    check_next();
    push("timer_2frames", 1, 3, 16, 0, 0, 0, 0, 3);
    frames(2);
    check_next();
    push("timer_lose", 1, 2, 16, 1, 0, 0, 0, 3);
    pulse(1'b0, 1'b1);
    check_next();
    push("timer_frozen", 1, 2, 16, 1, 0, 0, 0, 3);
    frames(30);
    check_next();
    push("timer_reload", 1, 2, 16, 0, 1, 0, 0, 5);
    frames(30);
    check_next();
    push("timer_4frames", 1, 2, 16, 0, 0, 0, 0, 1);
    frames(4);
    check_next();
    push("timer_expired", 1, 1, 16, 1, 0, 0, 0, 0);
    frames(1);
    check_next();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
